hdmi_timing_gen: RTL and testbench

- Generates raster timing for the HDMI transmitter: HSYNC, VSYNC and DE, plus a linear pixel-ROM read address per active pixel.
- Sits between the pixel clock source and the pixel output stage: drives the image ROM address bus and the HDMI sync pins.
- Delays the sync/DE signals to line up with the synchronous ROM read latency, so ROM data and DE arrive at the output on the same cycle.
- Starts only after the transmitter's I2C configuration has completed.

---
 rtl/hdmi_timing_gen.sv | 217 +++++++++++++++++++++
 tb/tb_hdmi_timing_gen.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: raster timing generator for the HDMI transmitter.
//
// Produces the pixel-ROM read address for every active pixel, and HSYNC, VSYNC,
// DE and FRAME_START delayed so that they line up with the ROM read data.
//
// Ports:
//   CLK_PX      in   pixel clock
//   RST         in   synchronous reset, active-high (overrides EN)
//   EN          in   run enable (I2C configuration done)
//   PX_ADDR     out  image ROM read address
//   ADDR_VALID  out  PX_ADDR refers to an active pixel
//   X, Y        out  column / row of the current PX_ADDR
//   DE          out  data enable, aligned to ROM data
//   HSYNC       out  horizontal sync at HS_POL, aligned to ROM data
//   VSYNC       out  vertical sync at VS_POL, aligned to ROM data
//   FRAME_START out  one-cycle pulse on pixel (0,0), aligned to DE
//
// Build option: define HDMI_TIMING_SCALE2_EN for pixel doubling of a
// half-resolution image (PX_ADDR = (Y>>1)*(H_ACTIVE/2) + (X>>1)). Without it the
// address is linear, one ROM word per active pixel.
//
// PIPE_DLY must lie in 1..4; X/Y are 10 bits, so H_TOT and V_TOT must fit 10 bits.

module hdmi_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned PIPE_DLY   = 2,
  parameter int unsigned ADDR_WIDTH = 19
) (
  input  logic                  CLK_PX,
  input  logic                  RST,
  input  logic                  EN,
  output logic [ADDR_WIDTH-1:0] PX_ADDR,
  output logic                  ADDR_VALID,
  output logic [9:0]            X,
  output logic [9:0]            Y,
  output logic                  DE,
  output logic                  HSYNC,
  output logic                  VSYNC,
  output logic                  FRAME_START
);

  localparam int unsigned HTot = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Raw decode is registered once into the address stage, then PIPE_DLY more.
  localparam int unsigned Dly  = 1 + PIPE_DLY;

  localparam logic [9:0] HActEnd  = 10'(H_ACTIVE);
  localparam logic [9:0] HSyncBeg = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HLast    = 10'(HTot - 1);
  localparam logic [9:0] VActEnd  = 10'(V_ACTIVE);
  localparam logic [9:0] VSyncBeg = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VLast    = 10'(VTot - 1);

  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

  // Stage 0 counters
  logic [9:0] h_ctr_q, h_ctr_d;
  logic [9:0] v_ctr_q, v_ctr_d;
  logic       h_wrap, v_wrap;

  // Raw decode, gated by EN so a disabled generator feeds inactive values
  logic act, hs, vs, fs;

  // Address stage
  logic [ADDR_WIDTH-1:0] px_addr_q, px_addr_d;
  logic                  addr_valid_q, addr_valid_d;
  logic [9:0]            x_q, x_d;
  logic [9:0]            y_q, y_d;

`ifdef HDMI_TIMING_SCALE2_EN
  logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  localparam logic [ADDR_WIDTH-1:0] HalfLine = ADDR_WIDTH'(H_ACTIVE / 2);
`else
  // Address to hand to the next active pixel of the frame
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
`endif

  // Output delay lines; index Dly-1 drives the pins
  logic [Dly-1:0] de_pipe_q, de_pipe_d;
  logic [Dly-1:0] hs_pipe_q, hs_pipe_d;
  logic [Dly-1:0] vs_pipe_q, vs_pipe_d;
  logic [Dly-1:0] fs_pipe_q, fs_pipe_d;

  always_comb begin
    h_wrap = (h_ctr_q == HLast);
    v_wrap = (v_ctr_q == VLast);

    act = EN && (h_ctr_q < HActEnd) && (v_ctr_q < VActEnd);
    hs  = EN && (h_ctr_q >= HSyncBeg) && (h_ctr_q < HSyncEnd);
    vs  = EN && (v_ctr_q >= VSyncBeg) && (v_ctr_q < VSyncEnd);
    fs  = EN && (h_ctr_q == 10'd0) && (v_ctr_q == 10'd0);

    h_ctr_d = h_ctr_q;
    v_ctr_d = v_ctr_q;
    if (!EN) begin
      h_ctr_d = 10'd0;
      v_ctr_d = 10'd0;
    end else if (h_wrap) begin
      h_ctr_d = 10'd0;
      v_ctr_d = v_wrap ? 10'd0 : v_ctr_q + 10'd1;
    end else begin
      h_ctr_d = h_ctr_q + 10'd1;
    end
  end

  always_comb begin
    addr_valid_d = act;
    x_d          = h_ctr_q;
    y_d          = v_ctr_q;
    px_addr_d    = px_addr_q;
`ifdef HDMI_TIMING_SCALE2_EN
    line_base_d = line_base_q;
    col_d       = col_q;
    if (!EN) begin
      px_addr_d   = '0;
      line_base_d = '0;
      col_d       = '0;
    end else begin
      if (act) begin
        px_addr_d = line_base_q + col_q;
      end
      if (h_wrap) begin
        col_d = '0;
        // Each source line is shown twice: step the base after odd rows only.
        if (v_wrap) begin
          line_base_d = '0;
        end else if ((v_ctr_q < VActEnd) && v_ctr_q[0]) begin
          line_base_d = line_base_q + HalfLine;
        end
      end else if (act && h_ctr_q[0]) begin
        col_d = col_q + AddrOne;
      end
    end
`else
    cnt_d = cnt_q;
    if (!EN) begin
      px_addr_d = '0;
      cnt_d     = '0;
    end else if (act) begin
      if (fs) begin
        px_addr_d = '0;
        cnt_d     = AddrOne;
      end else begin
        px_addr_d = cnt_q;
        cnt_d     = cnt_q + AddrOne;
      end
    end
`endif
  end

  always_comb begin
    de_pipe_d = {de_pipe_q[Dly-2:0], act};
    hs_pipe_d = {hs_pipe_q[Dly-2:0], hs ? HS_POL : ~HS_POL};
    vs_pipe_d = {vs_pipe_q[Dly-2:0], vs ? VS_POL : ~VS_POL};
    fs_pipe_d = {fs_pipe_q[Dly-2:0], fs};
  end

  always_ff @(posedge CLK_PX) begin
    if (RST) begin
      h_ctr_q      <= '0;
      v_ctr_q      <= '0;
      px_addr_q    <= '0;
      addr_valid_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
`ifdef HDMI_TIMING_SCALE2_EN
      line_base_q  <= '0;
      col_q        <= '0;
`else
      cnt_q        <= '0;
`endif
      de_pipe_q    <= '0;
      hs_pipe_q    <= {Dly{~HS_POL}};
      vs_pipe_q    <= {Dly{~VS_POL}};
      fs_pipe_q    <= '0;
    end else begin
      h_ctr_q      <= h_ctr_d;
      v_ctr_q      <= v_ctr_d;
      px_addr_q    <= px_addr_d;
      addr_valid_q <= addr_valid_d;
      x_q          <= x_d;
      y_q          <= y_d;
`ifdef HDMI_TIMING_SCALE2_EN
      line_base_q  <= line_base_d;
      col_q        <= col_d;
`else
      cnt_q        <= cnt_d;
`endif
      de_pipe_q    <= de_pipe_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      fs_pipe_q    <= fs_pipe_d;
    end
  end

  assign PX_ADDR     = px_addr_q;
  assign ADDR_VALID  = addr_valid_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign DE          = de_pipe_q[Dly-1];
  assign HSYNC       = hs_pipe_q[Dly-1];
  assign VSYNC       = vs_pipe_q[Dly-1];
  assign FRAME_START = fs_pipe_q[Dly-1];

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Self-checking bench for hdmi_timing_gen on a reduced raster (25 x 15 totals,
// 16 x 8 active) so that whole frames fit in a short run.

module tb_hdmi_timing_gen;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSW = 4;
  localparam int HBP = 3;
  localparam int VA  = 8;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int PD  = 2;
  localparam int AW  = 19;
  localparam int HTOT = HA + HFP + HSW + HBP;
  localparam int VTOT = VA + VFP + VSW + VBP;

  logic          CLK_PX;
  logic          RST;
  logic          EN;
  logic [AW-1:0] PX_ADDR;
  logic          ADDR_VALID;
  logic [9:0]    X;
  logic [9:0]    Y;
  logic          DE;
  logic          HSYNC;
  logic          VSYNC;
  logic          FRAME_START;

  hdmi_timing_gen #(
    .H_ACTIVE  (HA),
    .H_FP      (HFP),
    .H_SYNC    (HSW),
    .H_BP      (HBP),
    .V_ACTIVE  (VA),
    .V_FP      (VFP),
    .V_SYNC    (VSW),
    .V_BP      (VBP),
    .HS_POL    (1'b0),
    .VS_POL    (1'b0),
    .PIPE_DLY  (PD),
    .ADDR_WIDTH(AW)
  ) dut (
    .CLK_PX     (CLK_PX),
    .RST        (RST),
    .EN         (EN),
    .PX_ADDR    (PX_ADDR),
    .ADDR_VALID (ADDR_VALID),
    .X          (X),
    .Y          (Y),
    .DE         (DE),
    .HSYNC      (HSYNC),
    .VSYNC      (VSYNC),
    .FRAME_START(FRAME_START)
  );

  initial CLK_PX = 1'b0;
  always #5 CLK_PX = ~CLK_PX;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference address of raster pixel (h,v).
  function automatic int addr_of(input int h, input int v);
`ifdef HDMI_TIMING_SCALE2_EN
    return (v / 2) * (HA / 2) + (h / 2);
`else
    return v * HA + h;
`endif
  endfunction

  // One record per clock: was the generator running, and at which raster point.
  typedef struct {
    bit en;
    int h;
    int v;
  } rec_t;

  function automatic bit is_act(input rec_t r);
    return r.en && (r.h < HA) && (r.v < VA);
  endfunction

  // Model + per-cycle compare. The raster position is the number of enabled
  // cycles since the last start, folded into line/frame coordinates.
  rec_t hist[0:PD];
  int   t_run;
  int   exp_addr;

  initial begin
    rec_t nr;
    rec_t d;
    bit   rst_s;
    bit   en_s;
    for (int i = 0; i <= PD; i++) hist[i] = '{en: 1'b0, h: 0, v: 0};
    t_run    = 0;
    exp_addr = 0;
    forever begin
      @(posedge CLK_PX);
      rst_s = RST;
      en_s  = EN;
      if (rst_s) begin
        for (int i = 0; i <= PD; i++) hist[i] = '{en: 1'b0, h: 0, v: 0};
        t_run    = 0;
        exp_addr = 0;
      end else begin
        nr.en = en_s;
        nr.h  = t_run % HTOT;
        nr.v  = (t_run / HTOT) % VTOT;
        for (int i = PD; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = nr;
        if (!en_s) begin
          t_run    = 0;
          exp_addr = 0;
        end else begin
          t_run++;
          if (is_act(nr)) exp_addr = addr_of(nr.h, nr.v);
        end
      end
      cyc++;
      #1;
      d = hist[PD];
      chk("m_addr_valid", int'(ADDR_VALID), int'(is_act(hist[0])));
      chk("m_x", int'(X), hist[0].h);
      chk("m_y", int'(Y), hist[0].v);
      chk("m_px_addr", int'(PX_ADDR), exp_addr);
      chk("m_de", int'(DE), int'(is_act(d)));
      chk("m_hsync", int'(HSYNC),
          (d.en && d.h >= HA + HFP && d.h < HA + HFP + HSW) ? 0 : 1);
      chk("m_vsync", int'(VSYNC),
          (d.en && d.v >= VA + VFP && d.v < VA + VFP + VSW) ? 0 : 1);
      chk("m_frame_start", int'(FRAME_START), int'(d.en && d.h == 0 && d.v == 0));
    end
  end

  // Hand-computed addresses for selected pixels.
`ifdef HDMI_TIMING_SCALE2_EN
  localparam int NLIT = 7;
  int lit_x[NLIT] = '{0, 1, 0, 1, 2, 0, 15};
  int lit_y[NLIT] = '{0, 0, 1, 1, 0, 2, 7};
  int lit_a[NLIT] = '{0, 0, 0, 0, 1, 8, 31};
  localparam int MAX_ADDR = 31;
`else
  localparam int NLIT = 5;
  int lit_x[NLIT] = '{0, 1, 0, 5, 15};
  int lit_y[NLIT] = '{0, 0, 1, 3, 7};
  int lit_a[NLIT] = '{0, 1, 16, 53, 127};
  localparam int MAX_ADDR = 127;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  t0;
    int  av_rise, de_rise1, de_rise2, fs1, fs2, de_run, hs_fall, hs_w, vs_fall, vs_w;
    int  max_addr, de_lines;
    bit  run_done, hs_done, vs_done, found;
    logic p_de, p_hs, p_vs, p_av;

    RST = 1'b1;
    EN  = 1'b1;
    repeat (3) begin
      @(negedge CLK_PX);
      chk("rst_de", int'(DE), 0);
      chk("rst_hsync", int'(HSYNC), 1);
      chk("rst_vsync", int'(VSYNC), 1);
      chk("rst_px_addr", int'(PX_ADDR), 0);
    end
    RST = 1'b0;
    t0  = cyc;

    av_rise = -1; de_rise1 = -1; de_rise2 = -1; fs1 = -1; fs2 = -1;
    de_run = 0; hs_fall = -1; hs_w = 0; vs_fall = -1; vs_w = 0;
    max_addr = 0; de_lines = 0;
    run_done = 0; hs_done = 0; vs_done = 0;
    p_de = 1'b0; p_hs = 1'b1; p_vs = 1'b1; p_av = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge CLK_PX);
      if (ADDR_VALID && !p_av && av_rise < 0) av_rise = k;
      if (FRAME_START) begin
        if (fs1 < 0) begin
          fs1 = k;
          chk("fs_x", int'(X), PD);
        end else if (fs2 < 0) begin
          fs2 = k;
        end
      end
      if (DE && !p_de) begin
        if (de_rise1 < 0) de_rise1 = k;
        else if (de_rise2 < 0) de_rise2 = k;
        if (fs2 < 0) de_lines++;
      end
      if (de_rise1 > 0 && !run_done) begin
        if (DE) de_run++;
        else run_done = 1;
      end
      if (!HSYNC && p_hs && hs_fall < 0) hs_fall = k;
      if (hs_fall > 0 && !hs_done) begin
        if (!HSYNC) hs_w++;
        else hs_done = 1;
      end
      if (!VSYNC && p_vs && vs_fall < 0) vs_fall = k;
      if (vs_fall > 0 && !vs_done) begin
        if (!VSYNC) vs_w++;
        else vs_done = 1;
      end
      if (ADDR_VALID) begin
        if (int'(PX_ADDR) > max_addr) max_addr = int'(PX_ADDR);
        for (int i = 0; i < NLIT; i++) begin
          if (int'(X) == lit_x[i] && int'(Y) == lit_y[i]) chk("lit_addr", int'(PX_ADDR), lit_a[i]);
        end
      end
      p_de = DE; p_hs = HSYNC; p_vs = VSYNC; p_av = ADDR_VALID;
    end
    chk("first_addr_valid", av_rise, 1);
    chk("first_frame_start", fs1, 3);
    chk("first_de", de_rise1, 3);
    chk("de_run_len", de_run, 16);
    chk("line_period", de_rise2 - de_rise1, 25);
    chk("hsync_offset", hs_fall - de_rise1, 18);
    chk("hsync_width", hs_w, 4);
    chk("vsync_offset", vs_fall - de_rise1, 250);
    chk("vsync_width", vs_w, 50);
    chk("frame_period", fs2 - fs1, 375);
    chk("de_lines", de_lines, 8);
    chk("max_addr", max_addr, MAX_ADDR);

    // Drop EN mid-line while the address stage shows pixel (5,3).
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge CLK_PX);
      if (ADDR_VALID && X == 10'd5 && Y == 10'd3) found = 1;
    end
    chk("wait_pixel_5_3", int'(found), 1);
    EN = 1'b0;
    repeat (3) @(negedge CLK_PX);
    chk("en_off_de", int'(DE), 0);
    chk("en_off_hsync", int'(HSYNC), 1);
    chk("en_off_vsync", int'(VSYNC), 1);
    repeat (4) @(negedge CLK_PX);
    chk("en_off_px_addr", int'(PX_ADDR), 0);
    EN = 1'b1;
    @(negedge CLK_PX);
    chk("restart_addr_valid", int'(ADDR_VALID), 1);
    chk("restart_x", int'(X), 0);
    chk("restart_y", int'(Y), 0);
    chk("restart_px_addr", int'(PX_ADDR), 0);
    repeat (2) @(negedge CLK_PX);
    chk("restart_frame_start", int'(FRAME_START), 1);

    // Reset for one cycle while DE is high on line 2.
    repeat (50) @(negedge CLK_PX);
    chk("pre_rst_de", int'(DE), 1);
    RST = 1'b1;
    @(negedge CLK_PX);
    RST = 1'b0;
    chk("mid_rst_de", int'(DE), 0);
    chk("mid_rst_hsync", int'(HSYNC), 1);
    chk("mid_rst_vsync", int'(VSYNC), 1);
    chk("mid_rst_addr_valid", int'(ADDR_VALID), 0);
    chk("mid_rst_px_addr", int'(PX_ADDR), 0);
    chk("mid_rst_frame_start", int'(FRAME_START), 0);
    chk("mid_rst_x", int'(X), 0);
    repeat (2) @(negedge CLK_PX);
    chk("post_rst_fs_early", int'(FRAME_START), 0);
    @(negedge CLK_PX);
    chk("post_rst_frame_start", int'(FRAME_START), 1);
    repeat (20) @(negedge CLK_PX);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
